// File: rtl/cic_decim_var.sv
// Variable-rate N-stage CIC decimator with rate-dependent gain normalisation,
// round-half-up, saturation and a registered bypass path.
module cic_decim_var #(
  parameter int IWIDTH  = 18,
  parameter int OWIDTH  = 18,
  parameter int N       = 4,
  parameter int MAXLOG2 = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              bypass,
  input  logic [7:0]        rate,
  input  logic              stb_in,
  input  logic [IWIDTH-1:0] data_in,
  output logic              stb_out,
  output logic [OWIDTH-1:0] data_out
);

  localparam int AW   = IWIDTH + N * MAXLOG2;
  localparam int SW   = $clog2(N * MAXLOG2 + 1);
  localparam int RMAX = 1 << MAXLOG2;

  localparam logic signed [AW:0] OMAX = (AW + 1)'(2 ** (OWIDTH - 1) - 1);
  localparam logic signed [AW:0] OMIN = ~OMAX;

  function automatic logic [7:0] clamp_rate(input logic [7:0] r);
    if (r < 8'd2)
      return 8'd2;
    else if ({1'b0, r} > 9'(RMAX))
      return 8'(RMAX);
    else
      return r;
  endfunction

  // N * ceil(log2(r)): smallest power of two not below r, times the stage count
  function automatic logic [SW-1:0] shift_for(input logic [7:0] r);
    int lg;
    lg = 0;
    for (int i = 0; i < 8; i++)
      if ((9'd1 << i) < {1'b0, r}) lg = i + 1;
    return SW'(N * lg);
  endfunction

  function automatic logic signed [AW:0] round_shift(input logic signed [AW-1:0] x,
                                                     input logic [SW-1:0] sh);
    logic signed [AW:0] half;
    logic signed [AW:0] v;
    half = (AW + 1)'(1) << (sh - SW'(1));
    v    = $signed({x[AW-1], x}) + half;
    v    = v >>> sh;
    return v;
  endfunction

  function automatic logic [OWIDTH-1:0] saturate(input logic signed [AW:0] v);
    if (v > OMAX)
      return OMAX[OWIDTH-1:0];
    else if (v < OMIN)
      return OMIN[OWIDTH-1:0];
    else
      return v[OWIDTH-1:0];
  endfunction

  logic                 clr;
  logic [7:0]           rate_cl;
  logic [7:0]           rate_q;
  logic [7:0]           cnt_q;
  logic                 dec_stb;
  logic [SW-1:0]        win_shift;
  logic [OWIDTH-1:0]    byp_val;

  logic signed [AW-1:0] integ_q  [N];
  logic signed [AW-1:0] integ_d  [N];
  logic signed [AW-1:0] cx       [N];
  logic                 cvin     [N];
  logic [SW-1:0]        cshin    [N];
  logic signed [AW-1:0] cy_q     [N];
  logic signed [AW-1:0] cprev_q  [N];
  logic                 cvld_q   [N];
  logic [SW-1:0]        csh_q    [N];

  logic [OWIDTH-1:0]    norm_p1_q;
  logic                 vld_p1_q;

  assign clr       = rst || !enable;
  assign rate_cl   = clamp_rate(rate);
  assign dec_stb   = stb_in && (cnt_q == 8'd0);
  assign win_shift = shift_for(rate_q);

  generate
    if (OWIDTH <= IWIDTH) begin : g_byp_trunc
      assign byp_val = data_in[IWIDTH-1 -: OWIDTH];
    end else begin : g_byp_ext
      assign byp_val = {{(OWIDTH - IWIDTH){data_in[IWIDTH-1]}}, data_in};
    end
  endgenerate

  // ---- integrators and decimation counter (input rate) ----
  always_comb begin
    integ_d[0] = integ_q[0] + $signed({{(AW - IWIDTH){data_in[IWIDTH-1]}}, data_in});
    for (int k = 1; k < N; k++)
      integ_d[k] = integ_q[k] + integ_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < N; k++) integ_q[k] <= '0;
    end else if (stb_in) begin
      for (int k = 0; k < N; k++) integ_q[k] <= integ_d[k];
    end
  end

  // The rate is only picked up at a window boundary so a window never changes length midway
  always_ff @(posedge clk) begin
    if (clr) begin
      rate_q <= rate_cl;
      cnt_q  <= rate_cl - 8'd1;
    end else if (stb_in) begin
      if (cnt_q == 8'd0) begin
        rate_q <= rate_cl;
        cnt_q  <= rate_cl - 8'd1;
      end else begin
        cnt_q  <= cnt_q - 8'd1;
      end
    end
  end

  // ---- comb pipeline, one stage per clk; shift rides with the window ----
  always_comb begin
    cx[0]    = integ_d[N-1];
    cvin[0]  = dec_stb;
    cshin[0] = win_shift;
    for (int k = 1; k < N; k++) begin
      cx[k]    = cy_q[k-1];
      cvin[k]  = cvld_q[k-1];
      cshin[k] = csh_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < N; k++) begin
        cvld_q[k]  <= 1'b0;
        cy_q[k]    <= '0;
        cprev_q[k] <= '0;
        csh_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        cvld_q[k] <= cvin[k];
        if (cvin[k]) begin
          cy_q[k]    <= cx[k] - cprev_q[k];
          cprev_q[k] <= cx[k];
          csh_q[k]   <= cshin[k];
        end
      end
    end
  end

  // ---- normalise: round-half-up shift then saturate ----
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p1_q  <= 1'b0;
      norm_p1_q <= '0;
    end else begin
      vld_p1_q <= cvld_q[N-1];
      if (cvld_q[N-1])
        norm_p1_q <= saturate(round_shift(cy_q[N-1], csh_q[N-1]));
    end
  end

  // ---- output register: bypass wins over filtered path ----
  always_ff @(posedge clk) begin
    if (clr) begin
      stb_out  <= 1'b0;
      data_out <= '0;
    end else if (bypass) begin
      stb_out <= stb_in;
      if (stb_in) data_out <= byp_val;
    end else begin
      stb_out <= vld_p1_q;
      if (vld_p1_q) data_out <= norm_p1_q;
    end
  end

endmodule

// File: tb/tb_cic_decim_var.sv
// Directed bench for cic_decim_var: gain, rounding, latency, spacing, rate
// changes, reset/enable clearing, clamping and bypass.
module tb_cic_decim_var;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        bypass;
  logic [7:0]  rate;
  logic        stb_in;
  logic [17:0] data_in;
  logic        stb_out;
  logic [17:0] data_out;

  int cyc;
  int total;
  int bad;
  int ot[$];
  int ov[$];

  cic_decim_var #(.IWIDTH(18), .OWIDTH(18), .N(4), .MAXLOG2(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .bypass   (bypass),
    .rate     (rate),
    .stb_in   (stb_in),
    .data_in  (data_in),
    .stb_out  (stb_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // drive one cycle of input, then log any output strobe with its cycle index
  task automatic step(input logic s, input int d);
    stb_in  = s;
    data_in = d[17:0];
    @(posedge clk);
    #1;
    cyc++;
    if (stb_out === 1'b1) begin
      ot.push_back(cyc);
      ov.push_back(int'($signed(data_out)));
    end
  endtask

  task automatic do_reset(input int r);
    rate   = r[7:0];
    rst    = 1'b1;
    enable = 1'b1;
    bypass = 1'b0;
    step(1'b0, 0);
    rst = 1'b0;
    ot.delete();
    ov.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; bypass = 1'b0; rate = 8'd4;
    step(1'b0, 0);
    step(1'b1, 1000);
    total++;
    if (stb_out !== 1'b0) begin bad++; $display("FAIL reset_stb: got %0b want 0", stb_out); end
    total++;
    if (data_out !== 18'd0) begin bad++; $display("FAIL reset_data: got %0d want 0", data_out); end
    rst = 1'b0;
  endtask

  task automatic test_dc_rate4;
    int t0;
    do_reset(4);
    t0 = cyc;
    for (int i = 0; i < 56; i++) step(1'b1, 1000);
    total++;
    if (ot.size() !== 12) begin bad++; $display("FAIL r4_count: got %0d want 12", ot.size()); end
    else begin
      total++;
      if (ot[0] !== t0 + 9) begin bad++; $display("FAIL r4_first_time: got %0d want %0d", ot[0] - t0, 9); end
      total++;
      if (ov[0] !== 4) begin bad++; $display("FAIL r4_first_val: got %0d want 4", ov[0]); end
      for (int k = 1; k < 12; k++) begin
        total++;
        if (ot[k] - ot[k-1] !== 4) begin bad++; $display("FAIL r4_spacing[%0d]: got %0d want 4", k, ot[k] - ot[k-1]); end
      end
      for (int k = 5; k < 12; k++) begin
        total++;
        if (ov[k] !== 1000) begin bad++; $display("FAIL r4_dc[%0d]: got %0d want 1000", k, ov[k]); end
      end
    end
  endtask

  task automatic test_dc_rate5;
    do_reset(5);
    for (int i = 0; i < 60; i++) step(1'b1, 1000);
    total++;
    if (ot.size() !== 11) begin bad++; $display("FAIL r5_count: got %0d want 11", ot.size()); end
    else begin
      for (int k = 1; k < 11; k++) begin
        total++;
        if (ot[k] - ot[k-1] !== 5) begin bad++; $display("FAIL r5_spacing[%0d]: got %0d want 5", k, ot[k] - ot[k-1]); end
      end
      for (int k = 6; k < 11; k++) begin
        total++;
        if (ov[k] !== 153) begin bad++; $display("FAIL r5_dc[%0d]: got %0d want 153", k, ov[k]); end
      end
    end
  endtask

  task automatic test_full_scale;
    int lv[2];
    lv[0] = -131072;
    lv[1] = 131071;
    for (int p = 0; p < 2; p++) begin
      do_reset(128);
      for (int i = 0; i < 1040; i++) step(1'b1, lv[p]);
      total++;
      if (ot.size() !== 8) begin bad++; $display("FAIL fs_count[%0d]: got %0d want 8", p, ot.size()); end
      else begin
        total++;
        if (ot[7] - ot[6] !== 128) begin bad++; $display("FAIL fs_spacing[%0d]: got %0d want 128", p, ot[7] - ot[6]); end
        for (int k = 5; k < 8; k++) begin
          total++;
          if (ov[k] !== lv[p]) begin bad++; $display("FAIL fs_dc[%0d][%0d]: got %0d want %0d", p, k, ov[k], lv[p]); end
        end
      end
    end
  endtask

  task automatic test_latency;
    int t0;
    int et[5];
    int ev[5];
    et = '{7, 9, 11, 13, 15};
    ev = '{0, 256, 1536, 256, 0};
    do_reset(2);
    t0 = cyc;
    step(1'b1, 4096);
    for (int i = 1; i < 16; i++) step(1'b1, 0);
    total++;
    if (ot.size() !== 5) begin bad++; $display("FAIL lat_count: got %0d want 5", ot.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (ot[k] - t0 !== et[k]) begin bad++; $display("FAIL lat_time[%0d]: got %0d want %0d", k, ot[k] - t0, et[k]); end
        total++;
        if (ov[k] !== ev[k]) begin bad++; $display("FAIL lat_val[%0d]: got %0d want %0d", k, ov[k], ev[k]); end
      end
    end
  endtask

  task automatic test_rate_change;
    int t0;
    int et[7];
    et = '{27, 51, 75, 99, 111, 123, 135};
    do_reset(8);
    t0 = cyc;
    for (int i = 0; i < 138; i++) begin
      if (i == 78) rate = 8'd4;
      step(i % 3 == 0, 7);
    end
    total++;
    if (ot.size() !== 7) begin bad++; $display("FAIL rc_count: got %0d want 7", ot.size()); end
    else begin
      for (int k = 0; k < 7; k++) begin
        total++;
        if (ot[k] - t0 !== et[k]) begin bad++; $display("FAIL rc_time[%0d]: got %0d want %0d", k, ot[k] - t0, et[k]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int t1;
    do_reset(4);
    for (int i = 0; i < 30; i++) step(1'b1, 1000);
    total++;
    if ($signed(data_out) !== 1000) begin bad++; $display("FAIL rm_pre: got %0d want 1000", $signed(data_out)); end
    rst = 1'b1;
    step(1'b1, 1000);
    rst = 1'b0;
    total++;
    if (stb_out !== 1'b0) begin bad++; $display("FAIL rm_stb: got %0b want 0", stb_out); end
    total++;
    if (data_out !== 18'd0) begin bad++; $display("FAIL rm_data: got %0d want 0", data_out); end
    ot.delete();
    ov.delete();
    t1 = cyc;
    for (int i = 0; i < 14; i++) step(1'b1, 1000);
    total++;
    if (ot.size() !== 2) begin bad++; $display("FAIL rm_count: got %0d want 2", ot.size()); end
    else begin
      total++;
      if (ot[0] - t1 !== 9) begin bad++; $display("FAIL rm_first_time: got %0d want 9", ot[0] - t1); end
      total++;
      if (ov[0] !== 4) begin bad++; $display("FAIL rm_first_val: got %0d want 4", ov[0]); end
      total++;
      if (ov[1] !== 258) begin bad++; $display("FAIL rm_second_val: got %0d want 258", ov[1]); end
    end
  endtask

  task automatic test_enable;
    int t1;
    do_reset(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, 1000);
    total++;
    if (ot.size() !== 0) begin bad++; $display("FAIL en_off_strobes: got %0d want 0", ot.size()); end
    total++;
    if (data_out !== 18'd0) begin bad++; $display("FAIL en_off_data: got %0d want 0", data_out); end
    enable = 1'b1;
    t1 = cyc;
    for (int i = 0; i < 8; i++) step(1'b1, 1000);
    total++;
    if (ot.size() < 1) begin bad++; $display("FAIL en_on_count: got %0d want 1", ot.size()); end
    else begin
      total++;
      if (ot[0] - t1 !== 7) begin bad++; $display("FAIL en_on_time: got %0d want 7", ot[0] - t1); end
    end
  endtask

  task automatic test_clamp;
    int t0;
    do_reset(1);
    t0 = cyc;
    for (int i = 0; i < 12; i++) step(1'b1, 0);
    total++;
    if (ot.size() < 2) begin bad++; $display("FAIL cl_lo_count: got %0d want 3", ot.size()); end
    else begin
      total++;
      if (ot[0] - t0 !== 7) begin bad++; $display("FAIL cl_lo_time: got %0d want 7", ot[0] - t0); end
      total++;
      if (ot[1] - ot[0] !== 2) begin bad++; $display("FAIL cl_lo_spacing: got %0d want 2", ot[1] - ot[0]); end
    end
    do_reset(255);
    t0 = cyc;
    for (int i = 0; i < 140; i++) step(1'b1, 0);
    total++;
    if (ot.size() !== 1) begin bad++; $display("FAIL cl_hi_count: got %0d want 1", ot.size()); end
    else begin
      total++;
      if (ot[0] - t0 !== 133) begin bad++; $display("FAIL cl_hi_time: got %0d want 133", ot[0] - t0); end
    end
  endtask

  task automatic test_bypass;
    do_reset(4);
    bypass = 1'b1;
    step(1'b1, 18'h1ABCD);
    total++;
    if (stb_out !== 1'b1) begin bad++; $display("FAIL byp_stb: got %0b want 1", stb_out); end
    total++;
    if (data_out !== 18'h1ABCD) begin bad++; $display("FAIL byp_data: got %h want 1abcd", data_out); end
    step(1'b0, 5);
    total++;
    if (stb_out !== 1'b0) begin bad++; $display("FAIL byp_idle_stb: got %0b want 0", stb_out); end
    total++;
    if (data_out !== 18'h1ABCD) begin bad++; $display("FAIL byp_hold: got %h want 1abcd", data_out); end
    step(1'b1, -5);
    total++;
    if (data_out !== 18'h3FFFB) begin bad++; $display("FAIL byp_neg: got %h want 3fffb", data_out); end
    bypass = 1'b0;
    step(1'b0, 0);
  endtask

  initial begin
    cyc = 0; total = 0; bad = 0;
    rst = 1'b1; enable = 1'b0; bypass = 1'b0; rate = 8'd4;
    stb_in = 1'b0; data_in = '0;
    test_reset();
    test_dc_rate4();
    test_dc_rate5();
    test_full_scale();
    test_latency();
    test_rate_change();
    test_reset_mid();
    test_enable();
    test_clamp();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
